grant_data_collector: RTL and testbench

Sequential stage directly downstream of the two-request round-robin arbiter. Each cycle it takes the arbiter's grant vector and the two requesters' data words, and captures the granted word, tagged with its source index, into a first-word-fall-through FIFO with a valid/ready output. It also keeps saturating per-source acceptance counters and sticky error flags. The arbiter has no backpressure, so this block is the point where overflow and protocol violations are detected.

---
 rtl/grant_data_collector_if.sv | 23 ++
 rtl/grant_data_collector.sv | 102 ++++++++++
 tb/tb_grant_data_collector.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/grant_data_collector_if.sv
// Handshake bundle between the arbiter/requesters, the collector, and the downstream consumer.
// The collector takes the slave side; the stimulus/consumer side takes the master side.
interface grant_data_collector_if #(
  parameter int WIDTH = 8
);
  logic [1:0]       grants;
  logic [WIDTH-1:0] data0;
  logic [WIDTH-1:0] data1;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_source;

  modport master (
    output grants, data0, data1, out_ready,
    input  out_valid, out_data, out_source
  );

  modport slave (
    input  grants, data0, data1, out_ready,
    output out_valid, out_data, out_source
  );
endinterface

// File: rtl/grant_data_collector.sv
// Captures the arbiter's granted word (tagged with its source) into a first-word-fall-through FIFO.
// Also keeps saturating per-source acceptance counters and sticky overflow/illegal-grant flags.
module grant_data_collector #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  grant_data_collector_if.slave    bus,
  output logic [$clog2(DEPTH):0]   used,
  output logic [7:0]               cnt0,
  output logic [7:0]               cnt1,
  output logic                     overflow,
  output logic                     grant_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int UW = AW + 1;

  function automatic logic [7:0] sat_inc(input logic [7:0] c);
    return (c == 8'hFF) ? c : c + 8'd1;
  endfunction

  logic [WIDTH:0]   mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  logic             push_req;
  logic             push_src;
  logic [WIDTH-1:0] push_word;
  logic             pop;
  logic             full;
  logic             push_acc;
  logic             drop;
  logic             illegal;
  logic [WIDTH:0]   head;

  // Request decode and acceptance decision (pre-edge state only)
  always_comb begin
    push_req  = (bus.grants == 2'b01) || (bus.grants == 2'b10);
    push_src  = bus.grants[1];
    push_word = bus.grants[1] ? bus.data1 : bus.data0;
    illegal   = (bus.grants == 2'b11);
    full      = (used == UW'(DEPTH));
    pop       = bus.out_valid && bus.out_ready;
    push_acc  = push_req && (!full || pop);
    drop      = push_req && full && !pop;
  end

  // Storage write: no reset, contents are meaningless until pointed at
  always_ff @(posedge clk) begin
    if (!rst && push_acc) begin
      mem[wr_ptr] <= {push_src, push_word};
    end
  end

  // Control state: pointers, occupancy, counters, sticky flags
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      used      <= '0;
      cnt0      <= '0;
      cnt1      <= '0;
      overflow  <= 1'b0;
      grant_err <= 1'b0;
    end else begin
      if (push_acc) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push_acc, pop})
        2'b10:   used <= used + UW'(1);
        2'b01:   used <= used - UW'(1);
        default: used <= used;
      endcase
      if (push_acc && !push_src) begin
        cnt0 <= sat_inc(cnt0);
      end
      if (push_acc && push_src) begin
        cnt1 <= sat_inc(cnt1);
      end
      if (drop) begin
        overflow <= 1'b1;
      end
      if (illegal) begin
        grant_err <= 1'b1;
      end
    end
  end

  // Head outputs: masked while empty so unwritten storage never leaks X
  always_comb begin
    head           = mem[rd_ptr];
    bus.out_valid  = (used != '0);
    bus.out_data   = bus.out_valid ? head[WIDTH-1:0] : '0;
    bus.out_source = bus.out_valid ? head[WIDTH] : 1'b0;
  end

endmodule

// File: tb/tb_grant_data_collector.sv
// Directed test-plan steps followed by randomized traffic, all checked against a queue-based model.
module tb_grant_data_collector;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  logic [$clog2(DEPTH):0] used;
  logic [7:0] cnt0, cnt1;
  logic overflow, grant_err;

  grant_data_collector_if #(.WIDTH(WIDTH)) bus ();

  grant_data_collector #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .used      (used),
    .cnt0      (cnt0),
    .cnt1      (cnt1),
    .overflow  (overflow),
    .grant_err (grant_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: a plain queue of {source, data} plus scalar bookkeeping
  logic [WIDTH:0] q[$];
  int  m_cnt0, m_cnt1;
  bit  m_ovf, m_gerr;
  logic [WIDTH:0] popped[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_cnt0 = 0;
    m_cnt1 = 0;
    m_ovf  = 0;
    m_gerr = 0;
  endtask

  // One clock: drive inputs, advance model, check every output after the edge.
  task automatic cycle(input logic [1:0] g, input logic [7:0] d0, input logic [7:0] d1,
                       input logic rdy, input logic r);
    bit mpop, preq, acc;
    rst           = r;
    bus.grants    = g;
    bus.data0     = d0;
    bus.data1     = d1;
    bus.out_ready = rdy;
    mpop = (q.size() > 0) && rdy;
    preq = (g == 2'b01) || (g == 2'b10);
    acc  = preq && ((q.size() < DEPTH) || mpop);
    if (!r && mpop) popped.push_back({bus.out_source, bus.out_data});
    @(posedge clk);
    #1;
    if (r) begin
      model_reset();
    end else begin
      if (preq && !acc) m_ovf = 1;
      if (g == 2'b11) m_gerr = 1;
      if (mpop) void'(q.pop_front());
      if (acc) begin
        q.push_back({g == 2'b10, (g == 2'b10) ? d1 : d0});
        if (g == 2'b10) m_cnt1 = (m_cnt1 < 255) ? m_cnt1 + 1 : 255;
        else            m_cnt0 = (m_cnt0 < 255) ? m_cnt0 + 1 : 255;
      end
    end
    chk("out_valid", bus.out_valid, q.size() != 0);
    chk("used", used, q.size());
    chk("cnt0", cnt0, m_cnt0);
    chk("cnt1", cnt1, m_cnt1);
    chk("overflow", overflow, m_ovf);
    chk("grant_err", grant_err, m_gerr);
    if (q.size() != 0) begin
      chk("out_data", bus.out_data, q[0][WIDTH-1:0]);
      chk("out_source", bus.out_source, q[0][WIDTH]);
    end else begin
      chk("empty_data_noX", {31'd0, ^{bus.out_data, bus.out_source} === 1'bx}, 0);
    end
  endtask

  logic [WIDTH:0] arb_exp [4];
  logic [1:0]     arb_g   [5];
  int             u_before, c0_before, c1_before;

  initial begin
    model_reset();
    rst = 1'b1;
    bus.grants = 2'b00;
    bus.data0 = '0;
    bus.data1 = '0;
    bus.out_ready = 1'b0;

    // Reset then idle
    repeat (2) cycle(2'b00, 8'h00, 8'h00, 1'b0, 1'b1);
    repeat (5) cycle(2'b00, 8'h00, 8'h00, 1'b0, 1'b0);
    chk("idle_valid", bus.out_valid, 0);
    chk("idle_used", used, 0);
    chk("idle_flags", {overflow, grant_err}, 0);

    // Arbiter pattern with out_ready held high
    arb_g   = '{2'b01, 2'b00, 2'b10, 2'b01, 2'b10};
    arb_exp = '{9'h0A0, 9'h1B2, 9'h0A3, 9'h1B4};
    popped.delete();
    for (int i = 0; i < 5; i++) cycle(arb_g[i], 8'hA0 + 8'(i), 8'hB0 + 8'(i), 1'b1, 1'b0);
    cycle(2'b00, 8'h00, 8'h00, 1'b1, 1'b0);
    chk("arb_npop", popped.size(), 4);
    for (int i = 0; i < 4; i++) if (i < popped.size()) chk("arb_word", popped[i], arb_exp[i]);
    chk("arb_cnt0", cnt0, 2);
    chk("arb_cnt1", cnt1, 2);

    // Fill and overflow
    cycle(2'b00, 8'h00, 8'h00, 1'b0, 1'b1);
    for (int i = 1; i <= 5; i++) cycle(2'b01, 8'(i), 8'h00, 1'b0, 1'b0);
    chk("fill_used", used, 4);
    chk("fill_ovf", overflow, 1);
    chk("fill_cnt0", cnt0, 4);
    popped.delete();
    repeat (5) cycle(2'b00, 8'h00, 8'h00, 1'b1, 1'b0);
    chk("drain_npop", popped.size(), 4);
    for (int i = 0; i < 4; i++) if (i < popped.size()) chk("drain_word", popped[i], 9'(i + 1));
    chk("drain_valid", bus.out_valid, 0);

    // Full with simultaneous pop
    cycle(2'b00, 8'h00, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) cycle(2'b01, 8'h10 + 8'(i), 8'h00, 1'b0, 1'b0);
    popped.delete();
    cycle(2'b10, 8'h00, 8'h55, 1'b1, 1'b0);
    chk("fullpop_used", used, 4);
    chk("fullpop_ovf", overflow, 0);
    repeat (4) cycle(2'b00, 8'h00, 8'h00, 1'b1, 1'b0);
    chk("fullpop_npop", popped.size(), 5);
    if (popped.size() != 0) chk("fullpop_last", popped[popped.size() - 1], 9'h155);

    // Illegal grant
    cycle(2'b01, 8'h77, 8'h00, 1'b0, 1'b0);
    u_before = used; c0_before = cnt0; c1_before = cnt1;
    cycle(2'b11, 8'h88, 8'h99, 1'b0, 1'b0);
    chk("ill_gerr", grant_err, 1);
    chk("ill_used", used, u_before);
    chk("ill_cnt0", cnt0, c0_before);
    chk("ill_cnt1", cnt1, c1_before);
    repeat (3) cycle(2'b00, 8'h00, 8'h00, 1'b1, 1'b0);
    chk("ill_sticky", grant_err, 1);

    // Saturation then mid-stream reset
    for (int i = 0; i < 300; i++) cycle(2'b10, 8'h00, 8'($urandom), 1'b1, 1'b0);
    chk("sat_cnt1", cnt1, 255);
    chk("sat_used_le1", used <= 1, 1);
    cycle(2'b01, 8'hCC, 8'h00, 1'b1, 1'b1);
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_used", used, 0);
    chk("rst_cnts", {cnt0, cnt1}, 0);
    chk("rst_flags", {overflow, grant_err}, 0);

    // Randomized traffic with phases of light and heavy backpressure
    for (int i = 0; i < 3000; i++) begin
      logic [1:0] g;
      logic rdy, r;
      g   = 2'($urandom_range(0, 2));
      if ($urandom_range(0, 40) == 0) g = 2'b11;
      rdy = ((i / 200) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      r   = ($urandom_range(0, 499) == 0);
      cycle(g, 8'($urandom), 8'($urandom), rdy, r);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
